// File: rtl/header_unpacker_pkg.sv
// Shared definitions for the sample-header packer/unpacker pair: header
// slicing arithmetic and the frame state encoding.
package header_unpacker_pkg;

    // Header bits carried in the high-order part of each sample word.
    function automatic int pack_w(input int data_w, input int data_w_used);
        return data_w - data_w_used;
    endfunction

    // Number of sample words needed to carry a full header.
    function automatic int num_packs(input int meta_w, input int pk_w);
        return meta_w / pk_w;
    endfunction

    // True when the width parameters describe a legal packing.
    function automatic bit params_legal(input int data_w, input int data_w_used, input int meta_w);
        return (data_w_used < data_w) && ((meta_w % (data_w - data_w_used)) == 0);
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HEADER = 2'd1,
        ST_BODY   = 2'd2
    } frame_state_e;

endpackage

// File: rtl/header_shift_collector.sv
// Gathers the header nibble-by-nibble: first word ends up in the low bits.
// Tracks how many header words have been taken and flags the final one.
module header_shift_collector #(
    parameter int META_W    = 128,
    parameter int PACK_W    = 4,
    parameter int NUM_PACKS = 32,
    parameter int CNT_W     = 6
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clear_i,
    input  logic              shift_i,
    input  logic [PACK_W-1:0] pack_i,
    output logic [META_W-1:0] shift_next_o,
    output logic [CNT_W-1:0]  count_o,
    output logic              done_o
);

    logic [META_W-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]  count_q, count_d;

    // New bits enter at the top so earlier words migrate toward bit 0.
    assign shift_next_o = {pack_i, shift_q[META_W-1:PACK_W]};
    assign count_o      = count_q;
    assign done_o       = shift_i && !clear_i && (count_q == CNT_W'(NUM_PACKS - 1));

    // Next-state for shift register and word count; count saturates.
    always_comb begin
        shift_d = shift_q;
        count_d = count_q;
        if (clear_i) begin
            shift_d = '0;
            count_d = '0;
        end else if (shift_i) begin
            shift_d = shift_next_o;
            if (count_q != CNT_W'(NUM_PACKS))
                count_d = count_q + 1'b1;
        end
    end

    // Collector state registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shift_q <= '0;
            count_q <= '0;
        end else begin
            shift_q <= shift_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/header_unpacker.sv
// Receive side of the sample-header packer: strips the header bits off each
// sample word, reassembles the header, and emits clean extended samples.
module header_unpacker
    import header_unpacker_pkg::*;
#(
    parameter int data_width      = 16,
    parameter int data_width_used = 12,
    parameter int meta_data_width = 128,
    parameter int sign_extend     = 1
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       enable,
    input  logic                       init,
    input  logic [data_width-1:0]      data_in,
    input  logic                       strobe_in,
    output logic [data_width-1:0]      data_out,
    output logic                       strobe_out,
    output logic [meta_data_width-1:0] meta_data,
    output logic                       meta_valid,
    output logic                       header_short,
    output logic                       pad_error
);

    localparam int PACK_W    = pack_w(data_width, data_width_used);
    localparam int NUM_PACKS = num_packs(meta_data_width, PACK_W);
    localparam int CNT_W     = $clog2(NUM_PACKS) + 1;

    if (!params_legal(data_width, data_width_used, meta_data_width)) begin : g_bad_params
        $error("header_unpacker: illegal data_width/data_width_used/meta_data_width");
    end

    frame_state_e                state_q, state_d;
    logic [data_width-1:0]       data_q, data_d;
    logic                        strobe_q, strobe_d;
    logic [meta_data_width-1:0]  meta_q, meta_d;
    logic                        mvalid_q, mvalid_d;
    logic                        short_q, short_d;
    logic                        pad_q, pad_d;

    logic                        clr;
    logic                        shift_en;
    logic [meta_data_width-1:0]  hdr_next;
    logic [CNT_W-1:0]            hdr_cnt;
    logic                        hdr_done;
    logic [PACK_W-1:0]           ext;
    logic [PACK_W-1:0]           hi_bits;

    assign hi_bits = data_in[data_width-1:data_width_used];
    assign ext     = (sign_extend != 0) ? {PACK_W{data_in[data_width_used-1]}} : '0;

    header_shift_collector #(
        .META_W    (meta_data_width),
        .PACK_W    (PACK_W),
        .NUM_PACKS (NUM_PACKS),
        .CNT_W     (CNT_W)
    ) u_collect (
        .clock        (clock),
        .reset        (reset),
        .clear_i      (clr),
        .shift_i      (shift_en),
        .pack_i       (hi_bits),
        .shift_next_o (hdr_next),
        .count_o      (hdr_cnt),
        .done_o       (hdr_done)
    );

    // Frame FSM and output next-state: enable low beats init beats strobe.
    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        strobe_d = 1'b0;
        meta_d   = meta_q;
        mvalid_d = mvalid_q;
        short_d  = 1'b0;
        pad_d    = pad_q;
        clr      = 1'b0;
        shift_en = 1'b0;
        if (!enable) begin
            state_d  = ST_IDLE;
            mvalid_d = 1'b0;
            clr      = 1'b1;
        end else if (init) begin
            // Only a header that had started counts as cut short.
            short_d  = (state_q == ST_HEADER) && (hdr_cnt != '0);
            state_d  = ST_HEADER;
            mvalid_d = 1'b0;
            pad_d    = 1'b0;
            clr      = 1'b1;
        end else if (strobe_in) begin
            strobe_d = 1'b1;
            data_d   = {ext, data_in[data_width_used-1:0]};
            case (state_q)
                ST_HEADER: begin
                    shift_en = 1'b1;
                    if (hdr_done) begin
                        meta_d   = hdr_next;
                        mvalid_d = 1'b1;
                        state_d  = ST_BODY;
                    end
                end
                ST_BODY: begin
                    if (hi_bits != '0)
                        pad_d = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            data_q   <= '0;
            strobe_q <= 1'b0;
            meta_q   <= '0;
            mvalid_q <= 1'b0;
            short_q  <= 1'b0;
            pad_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            strobe_q <= strobe_d;
            meta_q   <= meta_d;
            mvalid_q <= mvalid_d;
            short_q  <= short_d;
            pad_q    <= pad_d;
        end
    end

    assign data_out     = data_q;
    assign strobe_out   = strobe_q;
    assign meta_data    = meta_q;
    assign meta_valid   = mvalid_q;
    assign header_short = short_q;
    assign pad_error    = pad_q;

endmodule

// File: tb/tb_header_unpacker.sv
// Self-checking bench: a word-level reference model runs alongside two DUT
// copies (sign-extending and zero-filling); every cycle is compared.
module tb_header_unpacker;

    localparam logic [127:0] META_A = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    localparam logic [127:0] META_B = 128'hDEAD_BEEF_0000_FFFF_1234_5678_9ABC_DEF0;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         enable = 1'b0;
    logic         init = 1'b0;
    logic [15:0]  data_in = '0;
    logic         strobe_in = 1'b0;

    logic [15:0]  dout, dout0;
    logic         sout, sout0;
    logic [127:0] meta, meta0;
    logic         mv, mv0, hs, hs0, pad, pad0;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    header_unpacker #(.sign_extend(1)) dut (
        .clock(clock), .reset(reset), .enable(enable), .init(init),
        .data_in(data_in), .strobe_in(strobe_in),
        .data_out(dout), .strobe_out(sout), .meta_data(meta),
        .meta_valid(mv), .header_short(hs), .pad_error(pad)
    );

    header_unpacker #(.sign_extend(0)) dut0 (
        .clock(clock), .reset(reset), .enable(enable), .init(init),
        .data_in(data_in), .strobe_in(strobe_in),
        .data_out(dout0), .strobe_out(sout0), .meta_data(meta0),
        .meta_valid(mv0), .header_short(hs0), .pad_error(pad0)
    );

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Frame mode: 0 = idle passthrough, 1 = header being collected, 2 = body.
    int           m_mode;
    int           m_words;
    logic [127:0] m_hdr, m_meta;
    logic [15:0]  m_dout, m_dout0;
    logic         m_sout, m_mv, m_hs, m_pad;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_mode = 0; m_words = 0; m_hdr = '0; m_meta = '0;
            m_dout = '0; m_dout0 = '0; m_sout = 0; m_mv = 0; m_hs = 0; m_pad = 0;
        end else if (!enable) begin
            m_sout = 0; m_mode = 0; m_words = 0; m_mv = 0; m_hs = 0;
        end else if (init) begin
            m_hs = (m_mode == 1) && (m_words > 0);
            m_mode = 1; m_words = 0; m_hdr = '0; m_mv = 0; m_pad = 0; m_sout = 0;
        end else begin
            m_hs = 0;
            if (strobe_in) begin
                logic [15:0] s;
                s = {4'h0, data_in[11:0]};
                m_sout  = 1;
                m_dout0 = s;
                m_dout  = s[11] ? (s | 16'hF000) : s;
                if (m_mode == 1) begin
                    m_hdr[m_words*4 +: 4] = data_in[15:12];
                    m_words++;
                    if (m_words == 32) begin
                        m_meta = m_hdr; m_mv = 1; m_mode = 2;
                    end
                end else if (m_mode == 2 && data_in[15:12] != 4'h0) begin
                    m_pad = 1;
                end
            end else begin
                m_sout = 0;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clock) begin
        chk("data_out", 128'(dout), 128'(m_dout));
        chk("data_out_zf", 128'(dout0), 128'(m_dout0));
        chk("strobe_out", 128'(sout), 128'(m_sout));
        chk("meta_data", meta, m_meta);
        chk("meta_valid", 128'(mv), 128'(m_mv));
        chk("header_short", 128'(hs), 128'(m_hs));
        chk("pad_error", 128'(pad), 128'(m_pad));
        chk("zf_misc", {meta0, sout0, mv0, hs0, pad0}, {meta, sout, mv, hs, pad});
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input logic en, input logic in, input logic stb, input logic [15:0] d);
        enable = en; init = in; strobe_in = stb; data_in = d;
        @(posedge clock);
        #2;
    endtask

    // One header word of meta value m at word position i carrying sample s.
    function automatic logic [15:0] hword(input logic [127:0] m, input int i, input logic [11:0] s);
        return {m[i*4 +: 4], s};
    endfunction

    initial begin
        @(posedge clock); @(posedge clock); #2;
        chk("reset_outputs", {dout, sout, meta, mv, hs, pad}, '0);
        reset = 1'b0;
        cyc(1, 0, 0, '0);

        // Round trip: header META_A in words 0..31, samples 0..39.
        cyc(1, 1, 0, '0);
        for (int i = 0; i < 40; i++) begin
            cyc(1, 0, 1, (i < 32) ? hword(META_A, i, 12'(i)) : 16'(i));
            chk("rt_data", 128'(dout), 128'(i));
            if (i == 30) chk("rt_mv_early", 128'(mv), 128'd0);
            if (i == 31) begin
                chk("rt_meta", meta, META_A);
                chk("rt_mv", 128'(mv), 128'd1);
            end
        end
        chk("rt_pad", 128'(pad), 128'd0);

        // Sign extension vs zero fill in the body.
        cyc(1, 0, 1, 16'h0800);
        chk("sext_on", 128'(dout), 128'h0000_F800);
        chk("sext_off", 128'(dout0), 128'h0000_0800);

        // Pad error is sticky until init.
        cyc(1, 0, 1, 16'h3123);
        chk("pad_data", 128'(dout), 128'h0123);
        chk("pad_set", 128'(pad), 128'd1);
        cyc(1, 0, 1, 16'h0001);
        chk("pad_sticky", 128'(pad), 128'd1);

        // Short frame: 10 header words then init again.
        cyc(1, 1, 0, '0);
        chk("pad_clr", 128'(pad), 128'd0);
        for (int i = 0; i < 10; i++) cyc(1, 0, 1, hword(META_B, i, 12'(i)));
        cyc(1, 1, 0, '0);
        chk("short_pulse", 128'(hs), 128'd1);
        chk("short_meta", meta, META_A);
        chk("short_mv", 128'(mv), 128'd0);
        cyc(1, 0, 0, '0);
        chk("short_once", 128'(hs), 128'd0);

        // init with strobe: word dropped, following 32 words make the header.
        cyc(1, 1, 1, 16'hFFFF);
        chk("initstb_no_out", 128'(sout), 128'd0);
        for (int i = 0; i < 32; i++) cyc(1, 0, 1, hword(META_B, i, 12'hA5A));
        chk("initstb_meta", meta, META_B);
        chk("initstb_mv", 128'(mv), 128'd1);

        // Enable drop mid-header: samples then pass through with no capture.
        cyc(1, 1, 0, '0);
        for (int i = 0; i < 5; i++) cyc(1, 0, 1, hword(META_A, i, 12'h111));
        cyc(0, 0, 1, 16'h1234);
        chk("en_low_sout", 128'(sout), 128'd0);
        for (int i = 0; i < 40; i++) cyc(1, 0, 1, hword(META_A, i, 12'(i)));
        chk("en_low_mv", 128'(mv), 128'd0);
        chk("en_low_meta", meta, META_B);

        // Async reset mid-body.
        cyc(1, 1, 0, '0);
        for (int i = 0; i < 34; i++) cyc(1, 0, 1, hword(META_A, i % 32, 12'hFFF));
        reset = 1'b1;
        #1;
        chk("async_reset", {dout, sout, meta, mv, hs, pad}, '0);
        @(posedge clock); #2;
        reset = 1'b0;
        cyc(1, 0, 0, '0);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            logic en, in, stb;
            logic [15:0] d;
            en  = ($urandom_range(49) != 0);
            in  = ($urandom_range(59) == 0);
            stb = ($urandom_range(3) != 0);
            d   = 16'($urandom);
            if ($urandom_range(2) == 0) d[15:12] = 4'h0;
            cyc(en, in, stb, d);
        end

        @(negedge clock); #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
